// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed active-low seven-segment bus: waits for each digit's
// anode/segment pair to settle, then decodes it into a per-digit code, DP flag and error flag.
module seven_segment_capture #(
    parameter int NUM_DIGITS       = 4,
    parameter int STABLE_CYCLES    = 4,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   i_an,
    input  logic [7:0]              i_seg,
    input  logic                    i_clr_err,
    output logic [4*NUM_DIGITS-1:0] o_digit_val,
    output logic [NUM_DIGITS-1:0]   o_dp_val,
    output logic                    o_upd_valid,
    output logic [IDX_W-1:0]        o_upd_idx,
    output logic                    o_frame_done,
    output logic                    o_err_sticky
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURED
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_seg;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [NUM_DIGITS-1:0]   r_lat_an;
    logic [NUM_DIGITS-1:0]   w_lat_an_next;
    logic [7:0]              r_lat_seg;
    logic [7:0]              w_lat_seg_next;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_next;
    logic [IDX_W-1:0]        w_an_idx;
    logic                    w_an_onehot;
    logic                    w_an_none;
    logic                    w_reeval;
    logic                    w_write;
    logic                    w_multi_err;
    logic                    w_err_set;
    logic [3:0]              w_code;
    logic                    w_illegal;
    logic                    r_upd_valid;
    logic [IDX_W-1:0]        r_upd_idx;
    logic                    r_frame_done;
    logic                    r_err_sticky;

    // Input stage; anodes normalised so that 1 always means "selected".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '0;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= (ANODE_ACTIVE_LOW != 0) ? ~i_an : i_an;
            r_seg <= i_seg;
        end
    end

    assign w_an_onehot = $onehot(r_an);
    assign w_an_none   = (r_an == '0);

    always_comb begin
        w_an_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_an[i]) begin
                w_an_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_code    = 4'hD;
        w_illegal = 1'b0;
        case (r_lat_seg[6:0])
            7'b1000000: w_code = 4'h0;
            7'b1111001: w_code = 4'h1;
            7'b0100100: w_code = 4'h2;
            7'b0110000: w_code = 4'h3;
            7'b0011001: w_code = 4'h4;
            7'b0010010: w_code = 4'h5;
            7'b0000010: w_code = 4'h6;
            7'b1111000: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0010000: w_code = 4'h9;
            7'b1010101: w_code = 4'hE;
            7'b1111111: w_code = 4'hF;
            default:    w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lat_an  <= '0;
            r_lat_seg <= 8'hFF;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_lat_an  <= w_lat_an_next;
            r_lat_seg <= w_lat_seg_next;
            r_idx     <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_lat_an_next  = r_lat_an;
        w_lat_seg_next = r_lat_seg;
        w_idx_next     = r_idx;
        w_reeval       = 1'b0;
        w_write        = 1'b0;
        w_multi_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_reeval = 1'b1;
            end
            S_SETTLE: begin
                if ((r_an != r_lat_an) || (r_seg != r_lat_seg)) begin
                    w_reeval = 1'b1;
                end else if (r_cnt == CNT_W'(STABLE_CYCLES)) begin
                    w_write      = 1'b1;
                    w_state_next = S_CAPTURED;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_CAPTURED: begin
                if (r_an != r_lat_an) begin
                    w_reeval = 1'b1;
                end else if (r_seg != r_lat_seg) begin
                    w_state_next   = S_SETTLE;
                    w_cnt_next     = CNT_W'(1);
                    w_lat_seg_next = r_seg;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        // Fresh look at the bus, shared by every state that sees the anodes move.
        if (w_reeval) begin
            if (w_an_onehot) begin
                w_state_next   = S_SETTLE;
                w_cnt_next     = CNT_W'(1);
                w_lat_an_next  = r_an;
                w_lat_seg_next = r_seg;
                w_idx_next     = w_an_idx;
            end else begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_multi_err  = !w_an_none;
            end
        end
    end

    assign w_err_set = w_multi_err | (w_write & w_illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_valid  <= 1'b0;
            r_upd_idx    <= '0;
            r_frame_done <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_upd_valid  <= w_write;
            r_frame_done <= w_write && (r_idx == IDX_W'(NUM_DIGITS - 1));
            if (w_write) begin
                r_upd_idx <= r_idx;
            end
            if (w_err_set) begin
                r_err_sticky <= 1'b1;
            end else if (i_clr_err) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            logic [3:0] r_digit;
            logic       r_dp;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_digit <= 4'hF;
                    r_dp    <= 1'b0;
                end else if (w_write && (r_idx == IDX_W'(gi))) begin
                    r_digit <= w_code;
                    r_dp    <= ~r_lat_seg[7];
                end
            end

            assign o_digit_val[4*gi +: 4] = r_digit;
            assign o_dp_val[gi]           = r_dp;
        end
    endgenerate

    assign o_upd_valid  = r_upd_valid;
    assign o_upd_idx    = r_upd_idx;
    assign o_frame_done = r_frame_done;
    assign o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (4 digits, 4 stable cycles, active-low anodes).
module tb_seven_segment_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_an;
    logic [7:0]  i_seg;
    logic        i_clr_err;
    logic [15:0] o_digit_val;
    logic [3:0]  o_dp_val;
    logic        o_upd_valid;
    logic [1:0]  o_upd_idx;
    logic        o_frame_done;
    logic        o_err_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seven_segment_capture #(
        .NUM_DIGITS      (4),
        .STABLE_CYCLES   (4),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_an        (i_an),
        .i_seg       (i_seg),
        .i_clr_err   (i_clr_err),
        .o_digit_val (o_digit_val),
        .o_dp_val    (o_dp_val),
        .o_upd_valid (o_upd_valid),
        .o_upd_idx   (o_upd_idx),
        .o_frame_done(o_frame_done),
        .o_err_sticky(o_err_sticky)
    );

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          hold;
        logic [15:0] exp_digits;
        logic [3:0]  exp_dp;
        logic        exp_err;
        int          exp_pulses;
        int          exp_frames;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int         pulses = 0;
        int         frames = 0;
        int         k_first = 0;
        logic [1:0] idx_seen = 2'd0;
        i_an  = v.an;
        i_seg = v.seg;
        for (int k = 1; k <= v.hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_upd_valid) begin
                pulses++;
                if (k_first == 0) k_first = k;
                idx_seen = o_upd_idx;
            end
            if (o_frame_done) frames++;
        end
        $display("vec %0d: an=%b seg=%h hold=%0d digits=%h dp=%b err=%b pulses=%0d frames=%0d",
                 n, v.an, v.seg, v.hold, o_digit_val, o_dp_val, o_err_sticky, pulses, frames);
        check($sformatf("vec%0d digit_val", n), 32'(o_digit_val), 32'(v.exp_digits));
        check($sformatf("vec%0d dp_val", n), 32'(o_dp_val), 32'(v.exp_dp));
        check($sformatf("vec%0d err_sticky", n), 32'(o_err_sticky), 32'(v.exp_err));
        check($sformatf("vec%0d pulses", n), 32'(pulses), 32'(v.exp_pulses));
        check($sformatf("vec%0d frames", n), 32'(frames), 32'(v.exp_frames));
        if (v.exp_pulses > 0) begin
            check($sformatf("vec%0d pulse_edge", n), 32'(k_first), 32'd6);
            check($sformatf("vec%0d upd_idx", n), 32'(idx_seen), 32'(v.exp_idx));
        end
    endtask

    initial begin
        int pulses;
        int k_first;

        //            an       seg    hold digits    dp       err  pls frm idx
        vecs[0]  = '{4'b1111, 8'hFF, 8, 16'hFFFF, 4'b0000, 1'b0, 0, 0, 2'd0};
        vecs[1]  = '{4'b1110, 8'hC0, 8, 16'hFFF0, 4'b0000, 1'b0, 1, 0, 2'd0};
        vecs[2]  = '{4'b1101, 8'h79, 8, 16'hFF10, 4'b0010, 1'b0, 1, 0, 2'd1};
        vecs[3]  = '{4'b1011, 8'hA4, 8, 16'hF210, 4'b0010, 1'b0, 1, 0, 2'd2};
        vecs[4]  = '{4'b0111, 8'hB0, 8, 16'h3210, 4'b0010, 1'b0, 1, 1, 2'd3};
        vecs[5]  = '{4'b1011, 8'h99, 3, 16'h3210, 4'b0010, 1'b0, 0, 0, 2'd0};
        vecs[6]  = '{4'b1111, 8'hFF, 8, 16'h3210, 4'b0010, 1'b0, 0, 0, 2'd0};
        vecs[7]  = '{4'b1110, 8'h8F, 8, 16'h321D, 4'b0010, 1'b1, 1, 0, 2'd0};
        vecs[8]  = '{4'b0111, 8'h55, 8, 16'hE21D, 4'b1010, 1'b1, 1, 1, 2'd3};
        vecs[9]  = '{4'b0111, 8'hB0, 8, 16'h321D, 4'b0010, 1'b1, 1, 1, 2'd3};
        vecs[10] = '{4'b0111, 8'hB0, 8, 16'h321D, 4'b0010, 1'b1, 0, 0, 2'd0};

        rst       = 1'b1;
        i_an      = 4'hF;
        i_seg     = 8'hFF;
        i_clr_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset: digits=%h dp=%b valid=%b idx=%0d frame=%b err=%b",
                 o_digit_val, o_dp_val, o_upd_valid, o_upd_idx, o_frame_done, o_err_sticky);
        check("reset digit_val", 32'(o_digit_val), 32'hFFFF);
        check("reset dp_val", 32'(o_dp_val), 32'h0);
        check("reset upd_valid", 32'(o_upd_valid), 32'h0);
        check("reset upd_idx", 32'(o_upd_idx), 32'h0);
        check("reset frame_done", 32'(o_frame_done), 32'h0);
        check("reset err_sticky", 32'(o_err_sticky), 32'h0);
        rst = 1'b0;

        for (int i = 0; i <= 6; i++) run_vec(i, vecs[i]);

        // Two anodes at once: error on sight, nothing captured.
        i_an  = 4'b1100;
        i_seg = 8'hC0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_upd_valid) pulses++;
        end
        $display("multi-anode: digits=%h err=%b pulses=%0d", o_digit_val, o_err_sticky, pulses);
        check("multi err_sticky", 32'(o_err_sticky), 32'h1);
        check("multi pulses", 32'(pulses), 32'h0);
        check("multi digit_val", 32'(o_digit_val), 32'h3210);

        // Clear while the error condition persists: set wins.
        i_clr_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_clr_err = 1'b0;
        $display("clr during multi: err=%b", o_err_sticky);
        check("clr_vs_set err_sticky", 32'(o_err_sticky), 32'h1);

        i_an = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_clr_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_clr_err = 1'b0;
        $display("clr idle: err=%b", o_err_sticky);
        check("clr err_sticky", 32'(o_err_sticky), 32'h0);

        for (int i = 7; i <= 10; i++) run_vec(i, vecs[i]);

        // Reset in the middle of settling digit 1.
        i_an  = 4'b1101;
        i_seg = 8'hF9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        $display("async reset: digits=%h dp=%b valid=%b idx=%0d frame=%b err=%b",
                 o_digit_val, o_dp_val, o_upd_valid, o_upd_idx, o_frame_done, o_err_sticky);
        check("async digit_val", 32'(o_digit_val), 32'hFFFF);
        check("async dp_val", 32'(o_dp_val), 32'h0);
        check("async upd_idx", 32'(o_upd_idx), 32'h0);
        check("async err_sticky", 32'(o_err_sticky), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses  = 0;
        k_first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_upd_valid) begin
                pulses++;
                if (k_first == 0) k_first = k;
            end
        end
        $display("post-reset settle: digits=%h pulses=%0d first=%0d", o_digit_val, pulses, k_first);
        check("post-reset pulses", 32'(pulses), 32'h1);
        check("post-reset pulse_edge", 32'(k_first), 32'd6);
        check("post-reset digit_val", 32'(o_digit_val), 32'hFF1F);
        check("post-reset dp_val", 32'(o_dp_val), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
